timer_cfg_seq: RTL and testbench
================================

# timer_cfg_seq

APB4 master sequencer that programs and supervises one timer peripheral on behalf of a single requester. A request carrying prescaler, compare, mode and an expiry count is turned into the fixed register-write sequence: disable, PSCR, CMP, enable. The block then optionally counts timer overflow interrupts, clearing each one by reading TIM_STAT, and stops the timer when the count is reached. It sits between a CPU-less control agent (DMA or test sequencer) and the timer's APB slave port.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: timer APB base address; register offsets are CTRL 0x00, PSCR 0x04, CNT 0x08, CMP 0x0C, STAT 0x10.
- TMO_WIDTH, 24: width of the per-interrupt wait watchdog.

Ports:
- clk_i, in, 1: single clock; all logic on its rising edge.
- rst_i, in, 1: reset, asynchronous active-high.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: high only in IDLE.
- req_pscr_i, in, 20: prescaler.
- req_cmp_i, in, 32: compare value.
- req_mode_i, in, 1: CTRL.MODE.
- req_etr_i, in, 1: CTRL.ETR.
- req_cnt_i, in, 8: overflows to wait for; 0 means program and return.
- req_tmo_i, in, TMO_WIDTH: max cycles per interrupt wait; 0 disables the watchdog.
- abort_i, in, 1: abort the current job.
- done_o, out, 1: one-cycle completion pulse.
- err_o, out, 2: result code, valid with done_o: 0 = ok, 1 = slverr, 2 = timeout, 3 = abort.
- busy_o, out, 1: high whenever the state is not IDLE.
- ovf_seen_o, out, 8: overflows counted in the current job.
- irq_i, in, 1: timer irq_o.
- APB master, all outputs registered:
  - paddr_o, out, 32.
  - psel_o, out, 1.
  - penable_o, out, 1.
  - pwrite_o, out, 1.
  - pwdata_o, out, 32.
  - pstrb_o, out, 4: always 4'hF.
  - pprot_o, out, 3: always 3'b000.
- APB master, inputs:
  - prdata_i, in, 32.
  - pready_i, in, 1.
  - pslverr_i, in, 1.

## Operation
- States: IDLE, WR_DIS, WR_PSCR, WR_CMP, WR_EN, WAIT_IRQ, RD_STAT, WR_STOP, DONE.
- Request acceptance:
  - A request is accepted when req_valid_i and req_ready_o are both high; all fields are latched on that edge.
  - After acceptance the state moves to WR_DIS.
- Register write sequence:
  - WR_DIS writes CTRL = 0.
  - WR_PSCR writes PSCR = max(req_pscr, 2), zero-extended. Values 0 and 1 are clamped to 2.
  - WR_CMP writes CMP = req_cmp.
  - WR_EN writes CTRL = {28'b0, mode, 1'b1, etr, ovie}, where ovie = (req_cnt != 0).
  - After WR_EN: go to DONE with err=0 if req_cnt == 0, otherwise to WAIT_IRQ.
- WAIT_IRQ:
  - Waits for a rising edge of irq_i, detected against a registered copy of irq_i that is cleared on entry to WAIT_IRQ.
  - The watchdog reloads from req_tmo on entry and decrements each cycle.
  - If the watchdog reaches 0 with req_tmo != 0, record err=2 and go to WR_STOP.
- RD_STAT:
  - Reads STAT; the read clears OVIF.
  - If prdata_i[0] == 1, increment ovf_seen.
  - If ovf_seen equals req_cnt, go to WR_STOP. Otherwise return to WAIT_IRQ.
  - A rising edge with OVIF == 0 is treated as spurious: return to WAIT_IRQ with no count.
- WR_STOP writes CTRL = 0, then goes to DONE.
- DONE:
  - Asserts done_o and err_o for one cycle, then returns to IDLE.
  - err_o and ovf_seen_o hold their values in IDLE until the next acceptance.
  - ovf_seen clears on acceptance.
- Slave errors:
  - pslverr_i sampled high on any completing transfer records err=1.
  - If the failing transfer is WR_STOP, go to DONE.
  - Otherwise go to WR_STOP; an error in that stop write does not loop.
- Abort:
  - abort_i is sampled in every non-IDLE, non-DONE state.
  - If a transfer is in progress, it completes first.
  - The block then records err=3 and goes to WR_STOP. If the state is already WR_STOP, it finishes that write.
  - The first recorded error wins.
  - abort_i in IDLE is ignored.

## Timing
- Each APB transfer uses a SETUP cycle (psel=1, penable=0), then ACCESS cycles (psel=1, penable=1) until pready_i.
- Address, data and write signals are stable across SETUP and ACCESS.
- psel_o drops for at least one cycle between transfers.
- Best case, acceptance to first SETUP is 1 cycle.
- With pready_i tied high, each state costs 3 cycles: SETUP, ACCESS and one gap.
- With req_cnt = 0 and pready_i high, done_o asserts 13 cycles after acceptance.
- An irq_i rising edge produces the RD_STAT SETUP 2 cycles later.
- Reset values:
  - req_ready_o = 1.
  - All other outputs 0, except pstrb_o = 4'hF.
  - The state is IDLE.
- Reset mid-transfer drops psel_o immediately; the timer is left as last programmed.

## Test plan
- Program only: pscr=100, cmp=0x3E8, mode=1, etr=0, cnt=0, pready=1.
  - Write sequence: 0x00←0, 0x04←100, 0x0C←0x3E8, 0x00←0xC.
  - done_o asserts 13 cycles after acceptance with err=0.
- Clamp and count: pscr=1, cnt=3, three irq pulses each with OVIF=1.
  - PSCR is written as 2.
  - STAT is read 3 times, then 0x00←0 is written.
  - Result: err=0, ovf_seen=3.
- Slave error: pslverr=1 on the CMP write.
  - Stop write 0x00←0 follows; then done with err=1.
- Timeout: cnt=2, tmo=50, no irq.
  - WR_STOP begins 50 cycles after entering WAIT_IRQ; done with err=2, ovf_seen=0.
- Abort and wait states: abort_i pulsed during the PSCR ACCESS phase, with pready held low for 4 cycles.
  - The PSCR transfer completes, then stop write, then done with err=3. CMP is never written.
- Reset and spurious irq:
  - An irq edge with OVIF=0 gives no increment and the block keeps waiting.
  - rst_i asserted mid-WAIT_IRQ gives all reset values in the same cycle.

Source files
------------

// File: rtl/timer_cfg_seq.sv
// rtl/timer_cfg_seq.sv - APB4 master that programs one timer and counts its overflow interrupts
module timer_cfg_seq #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TMO_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [19:0]          req_pscr_i,
    input  logic [31:0]          req_cmp_i,
    input  logic                 req_mode_i,
    input  logic                 req_etr_i,
    input  logic [7:0]           req_cnt_i,
    input  logic [TMO_WIDTH-1:0] req_tmo_i,
    input  logic                 abort_i,
    output logic                 done_o,
    output logic [1:0]           err_o,
    output logic                 busy_o,
    output logic [7:0]           ovf_seen_o,
    input  logic                 irq_i,
    output logic [31:0]          paddr_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [31:0]          pwdata_o,
    output logic [3:0]           pstrb_o,
    output logic [2:0]           pprot_o,
    input  logic [31:0]          prdata_i,
    input  logic                 pready_i,
    input  logic                 pslverr_i
);
    typedef enum logic [3:0] {
        S_IDLE, S_WR_DIS, S_WR_PSCR, S_WR_CMP, S_WR_EN,
        S_WAIT_IRQ, S_RD_STAT, S_WR_STOP, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS, PH_GAP} phase_t;

    localparam logic [1:0] ERR_SLV   = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    state_t state_q, state_d;
    phase_t ph_q, ph_d;

    logic [19:0]          pscr_q;
    logic [31:0]          cmp_q;
    logic                 mode_q, etr_q;
    logic [7:0]           cnt_q, ovf_q;
    logic [TMO_WIDTH-1:0] tmo_q, tmo_cnt_q;
    logic [1:0]           err_q, err_set;
    logic                 abort_pend_q, irq_q;
    logic                 abort_any, irq_rise, tmo_hit, accept, enter_wait;
    logic [4:0]           addr_off;
    logic [31:0]          wdata_d;
    logic [19:0]          pscr_clamp;
    logic                 unused_prdata;

    assign unused_prdata = ^prdata_i[31:1];
    assign accept      = (state_q == S_IDLE) && req_valid_i;
    assign abort_any   = abort_i || abort_pend_q;
    assign irq_rise    = irq_i && !irq_q;
    assign tmo_hit     = (tmo_q != '0) && (tmo_cnt_q == TMO_WIDTH'(1));
    assign enter_wait  = (state_d == S_WAIT_IRQ) && (state_q != S_WAIT_IRQ);
    assign pscr_clamp  = (pscr_q < 20'd2) ? 20'd2 : pscr_q;

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = err_q;
    assign ovf_seen_o  = ovf_q;
    assign pstrb_o     = 4'hF;
    assign pprot_o     = 3'b000;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ph_q    <= PH_IDLE;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
        end
    end

    // Transfer states run IDLE -> SETUP -> ACCESS -> GAP; the next state is chosen in GAP
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        err_set = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_WR_DIS;
                    ph_d    = PH_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ph_d    = PH_IDLE;
            end
            S_WAIT_IRQ: begin
                if (abort_any) begin
                    err_set = ERR_ABORT;
                    state_d = S_WR_STOP;
                    ph_d    = PH_IDLE;
                end else if (irq_rise) begin
                    state_d = S_RD_STAT;
                    ph_d    = PH_IDLE;
                end else if (tmo_hit) begin
                    err_set = ERR_TMO;
                    state_d = S_WR_STOP;
                    ph_d    = PH_IDLE;
                end
            end
            default: begin
                case (ph_q)
                    PH_IDLE: begin
                        if (abort_any && state_q != S_WR_STOP) begin
                            err_set = ERR_ABORT;
                            state_d = S_WR_STOP;
                        end else begin
                            ph_d = PH_SETUP;
                        end
                    end
                    PH_SETUP: ph_d = PH_ACCESS;
                    PH_ACCESS: begin
                        if (pready_i) begin
                            ph_d = PH_GAP;
                            if (pslverr_i) err_set = ERR_SLV;
                        end
                    end
                    default: begin
                        ph_d = PH_SETUP;
                        if (state_q == S_WR_STOP) begin
                            state_d = S_DONE;
                            ph_d    = PH_IDLE;
                        end else if (err_q != 2'd0 || abort_any) begin
                            if (abort_any) err_set = ERR_ABORT;
                            state_d = S_WR_STOP;
                        end else begin
                            case (state_q)
                                S_WR_DIS:  state_d = S_WR_PSCR;
                                S_WR_PSCR: state_d = S_WR_CMP;
                                S_WR_CMP:  state_d = S_WR_EN;
                                S_WR_EN: begin
                                    state_d = (cnt_q == 8'd0) ? S_DONE : S_WAIT_IRQ;
                                    ph_d    = PH_IDLE;
                                end
                                S_RD_STAT: begin
                                    if (ovf_q == cnt_q) begin
                                        state_d = S_WR_STOP;
                                    end else begin
                                        state_d = S_WAIT_IRQ;
                                        ph_d    = PH_IDLE;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        addr_off = 5'h00;
        wdata_d  = 32'd0;
        case (state_d)
            S_WR_PSCR: begin addr_off = 5'h04; wdata_d = {12'd0, pscr_clamp}; end
            S_WR_CMP:  begin addr_off = 5'h0C; wdata_d = cmp_q; end
            S_WR_EN:   begin addr_off = 5'h00; wdata_d = {28'd0, mode_q, 1'b1, etr_q, cnt_q != 8'd0}; end
            S_RD_STAT: begin addr_off = 5'h10; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            pwrite_o  <= 1'b0;
            paddr_o   <= 32'd0;
            pwdata_o  <= 32'd0;
        end else begin
            psel_o    <= (ph_d == PH_SETUP) || (ph_d == PH_ACCESS);
            penable_o <= (ph_d == PH_ACCESS);
            if (ph_d == PH_SETUP) begin
                paddr_o  <= BASE_ADDR + {27'd0, addr_off};
                pwdata_o <= wdata_d;
                pwrite_o <= (state_d != S_RD_STAT);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pscr_q       <= 20'd0;
            cmp_q        <= 32'd0;
            mode_q       <= 1'b0;
            etr_q        <= 1'b0;
            cnt_q        <= 8'd0;
            tmo_q        <= '0;
            tmo_cnt_q    <= '0;
            ovf_q        <= 8'd0;
            err_q        <= 2'd0;
            abort_pend_q <= 1'b0;
            irq_q        <= 1'b0;
        end else if (accept) begin
            pscr_q       <= req_pscr_i;
            cmp_q        <= req_cmp_i;
            mode_q       <= req_mode_i;
            etr_q        <= req_etr_i;
            cnt_q        <= req_cnt_i;
            tmo_q        <= req_tmo_i;
            ovf_q        <= 8'd0;
            err_q        <= 2'd0;
            abort_pend_q <= 1'b0;
            irq_q        <= irq_i;
        end else begin
            // First recorded error wins
            if (err_set != 2'd0 && err_q == 2'd0) err_q <= err_set;
            if (abort_i && state_q != S_IDLE && state_q != S_DONE) abort_pend_q <= 1'b1;
            if (state_q == S_RD_STAT && ph_q == PH_ACCESS && pready_i && !pslverr_i && prdata_i[0])
                ovf_q <= ovf_q + 8'd1;
            irq_q <= enter_wait ? 1'b0 : irq_i;
            if (enter_wait)
                tmo_cnt_q <= tmo_q;
            else if (state_q == S_WAIT_IRQ && tmo_cnt_q != '0)
                tmo_cnt_q <= tmo_cnt_q - TMO_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_timer_cfg_seq.sv
// tb/tb_timer_cfg_seq.sv - directed vector bench for timer_cfg_seq
module tb_timer_cfg_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_pscr = '0;
    logic [31:0] req_cmp = '0;
    logic        req_mode = 1'b0, req_etr = 1'b0;
    logic [7:0]  req_cnt = '0;
    logic [23:0] req_tmo = '0;
    logic        abort = 1'b0;
    logic        done, busy;
    logic [1:0]  err;
    logic [7:0]  ovf;
    logic        irq = 1'b0;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    logic        ready_en = 1'b1, err_en = 1'b0, stat_ovif = 1'b0;
    logic [31:0] err_addr = 32'h0;

    assign pready  = ready_en;
    assign pslverr = err_en && psel && penable && (paddr == err_addr);
    assign prdata  = {31'd0, stat_ovif};

    always #5 clk = ~clk;

    timer_cfg_seq #(.BASE_ADDR(32'h0000_0000), .TMO_WIDTH(24)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_pscr_i(req_pscr), .req_cmp_i(req_cmp), .req_mode_i(req_mode),
        .req_etr_i(req_etr), .req_cnt_i(req_cnt), .req_tmo_i(req_tmo),
        .abort_i(abort), .done_o(done), .err_o(err), .busy_o(busy),
        .ovf_seen_o(ovf), .irq_i(irq),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    typedef struct {
        logic [19:0] pscr;
        logic [31:0] cmp;
        logic        mode;
        logic        etr;
        logic [31:0] exp_pscr;
        logic [31:0] exp_en;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        int          setup;
    } xfer_t;

    vec_t  vecs[5];
    xfer_t xlog[$];
    int    cyc = 0;
    int    setup_cyc = 0;
    int    nvec = 0;
    int    nbad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (psel && !penable)
            setup_cyc = cyc;
        else if (psel && penable && pready)
            xlog.push_back('{paddr, pwrite, pwdata, setup_cyc});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [19:0] p, input logic [31:0] c, input logic m, input logic e,
                         input logic [7:0] n, input int t, output int acc);
        @(posedge clk); #1;
        chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        xlog.delete();
        req_pscr = p; req_cmp = c; req_mode = m; req_etr = e;
        req_cnt = n; req_tmo = 24'(t); req_valid = 1'b1;
        acc = cyc + 1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int dcyc, output logic [1:0] derr, output logic [7:0] dovf);
        logic found;
        found = 1'b0;
        dcyc = -1; derr = 2'd0; dovf = 8'd0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1; dcyc = cyc; derr = err; dovf = ovf;
                break;
            end
        end
        chk("done_seen", {31'd0, found}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic wait_log(input int n, input int max);
        for (int i = 0; i < max; i++) begin
            if (xlog.size() >= n) break;
            @(negedge clk);
        end
        chk("log_reached", {31'd0, xlog.size() >= n}, 32'd1);
    endtask

    task automatic pulse_irq(output int icyc);
        @(posedge clk); #1;
        irq = 1'b1;
        icyc = cyc;
        @(posedge clk); #1;
        irq = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, dcyc, icyc;
        logic [1:0] derr;
        logic [7:0] dovf;

        vecs[0] = '{20'd100,     32'h0000_03E8, 1'b1, 1'b0, 32'd100,     32'hC};
        vecs[1] = '{20'd0,       32'hFFFF_FFFF, 1'b0, 1'b1, 32'd2,       32'h6};
        vecs[2] = '{20'd1,       32'h0000_0005, 1'b1, 1'b1, 32'd2,       32'hE};
        vecs[3] = '{20'd2,       32'h0000_0007, 1'b0, 1'b0, 32'd2,       32'h4};
        vecs[4] = '{20'hF_FFFF,  32'h1234_5678, 1'b0, 1'b0, 32'h000F_FFFF, 32'h4};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pstrb", {28'd0, pstrb}, 32'hF);
        chk("rst_pprot", {29'd0, pprot}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, err}, 32'd0);

        // Program-only jobs
        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].pscr, vecs[v].cmp, vecs[v].mode, vecs[v].etr, 8'd0, 0, acc);
            wait_done(40, dcyc, derr, dovf);
            chk("prog_done_latency", 32'(dcyc - acc), 32'd13);
            chk("prog_err", {30'd0, derr}, 32'd0);
            chk("prog_nxfer", 32'(xlog.size()), 32'd4);
            if (xlog.size() == 4) begin
                chk("prog_first_setup", 32'(xlog[0].setup - acc), 32'd1);
                chk("prog_dis_addr", xlog[0].addr, 32'h00);
                chk("prog_dis_data", xlog[0].data, 32'h0);
                chk("prog_pscr_addr", xlog[1].addr, 32'h04);
                chk("prog_pscr_data", xlog[1].data, vecs[v].exp_pscr);
                chk("prog_cmp_addr", xlog[2].addr, 32'h0C);
                chk("prog_cmp_data", xlog[2].data, vecs[v].cmp);
                chk("prog_en_addr", xlog[3].addr, 32'h00);
                chk("prog_en_data", xlog[3].data, vecs[v].exp_en);
                chk("prog_en_write", {31'd0, xlog[3].wr}, 32'd1);
            end
        end

        // Clamp and count three overflows
        issue(20'd1, 32'd10, 1'b0, 1'b0, 8'd3, 0, acc);
        wait_log(4, 40);
        for (int k = 0; k < 3; k++) begin
            repeat (3) @(posedge clk);
            stat_ovif = 1'b1;
            pulse_irq(icyc);
            wait_log(5 + k, 20);
            if (k == 0 && xlog.size() >= 5)
                chk("irq_to_setup", 32'(xlog[4].setup - icyc), 32'd2);
        end
        wait_done(40, dcyc, derr, dovf);
        stat_ovif = 1'b0;
        chk("cnt_nxfer", 32'(xlog.size()), 32'd8);
        if (xlog.size() == 8) begin
            chk("cnt_pscr_clamp", xlog[1].data, 32'd2);
            chk("cnt_en_data", xlog[3].data, 32'h5);
            for (int k = 4; k < 7; k++) begin
                chk("cnt_stat_addr", xlog[k].addr, 32'h10);
                chk("cnt_stat_read", {31'd0, xlog[k].wr}, 32'd0);
            end
            chk("cnt_stop_addr", xlog[7].addr, 32'h00);
            chk("cnt_stop_data", xlog[7].data, 32'h0);
        end
        chk("cnt_err", {30'd0, derr}, 32'd0);
        chk("cnt_ovf", {24'd0, dovf}, 32'd3);
        chk("cnt_ovf_hold", {24'd0, ovf}, 32'd3);

        // Slave error on the CMP write
        err_addr = 32'h0C; err_en = 1'b1;
        issue(20'd10, 32'd3, 1'b0, 1'b0, 8'd0, 0, acc);
        wait_done(40, dcyc, derr, dovf);
        err_en = 1'b0;
        chk("slv_nxfer", 32'(xlog.size()), 32'd4);
        if (xlog.size() == 4) begin
            chk("slv_cmp_addr", xlog[2].addr, 32'h0C);
            chk("slv_stop_addr", xlog[3].addr, 32'h00);
            chk("slv_stop_data", xlog[3].data, 32'h0);
        end
        chk("slv_err", {30'd0, derr}, 32'd1);
        chk("slv_err_hold", {30'd0, err}, 32'd1);

        // Watchdog timeout with no interrupt
        issue(20'd5, 32'd9, 1'b0, 1'b0, 8'd2, 50, acc);
        wait_done(200, dcyc, derr, dovf);
        chk("tmo_nxfer", 32'(xlog.size()), 32'd5);
        if (xlog.size() == 5) begin
            chk("tmo_stop_delay", 32'(xlog[4].setup - xlog[3].setup), 32'd54);
            chk("tmo_stop_addr", xlog[4].addr, 32'h00);
            chk("tmo_stop_data", xlog[4].data, 32'h0);
        end
        chk("tmo_err", {30'd0, derr}, 32'd2);
        chk("tmo_ovf", {24'd0, dovf}, 32'd0);

        // Abort during a stalled PSCR access
        issue(20'd7, 32'd11, 1'b1, 1'b1, 8'd0, 0, acc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (psel && !penable && paddr == 32'h04) break;
        end
        ready_en = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 ready_en = 1'b1;
        wait_done(60, dcyc, derr, dovf);
        chk("abort_nxfer", 32'(xlog.size()), 32'd3);
        if (xlog.size() == 3) begin
            chk("abort_pscr_addr", xlog[1].addr, 32'h04);
            chk("abort_pscr_data", xlog[1].data, 32'd7);
            chk("abort_stop_addr", xlog[2].addr, 32'h00);
            chk("abort_stop_data", xlog[2].data, 32'h0);
        end
        chk("abort_err", {30'd0, derr}, 32'd3);

        // One real overflow, one spurious edge, then reset while waiting
        issue(20'd3, 32'd4, 1'b0, 1'b0, 8'd2, 0, acc);
        wait_log(4, 40);
        repeat (3) @(posedge clk);
        stat_ovif = 1'b1;
        pulse_irq(icyc);
        wait_log(5, 20);
        repeat (3) @(posedge clk);
        stat_ovif = 1'b0;
        pulse_irq(icyc);
        wait_log(6, 20);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("spur_ovf", {24'd0, ovf}, 32'd1);
        chk("spur_busy", {31'd0, busy}, 32'd1);
        chk("spur_nxfer", 32'(xlog.size()), 32'd6);
        chk("spur_psel", {31'd0, psel}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ovf", {24'd0, ovf}, 32'd0);
        chk("midrst_paddr", paddr, 32'h0);
        chk("midrst_psel", {31'd0, psel}, 32'd0);
        chk("midrst_err", {30'd0, err}, 32'd0);
        chk("midrst_pstrb", {28'd0, pstrb}, 32'hF);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
